// File: rtl/bla_pkg.sv
// Shared types and constants for the bla_arbiter slice.
package bla_pkg;

   localparam int COORD_W = 48;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RELEASE
   } arb_state_t;

endpackage

// File: rtl/bla_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request bit at or after
// rr_ptr, wrapping from NREQ-1 back to 0.
module rr_picker
   import bla_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_valid,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             any,
   output logic [IDX_W-1:0] win
);

   int unsigned idx;

   always_comb begin
      any = 1'b0;
      win = '0;
      idx = 0;
      for (int unsigned k = 0; k < unsigned'(NREQ); k++) begin
         idx = (32'(rr_ptr) + k) % unsigned'(NREQ);
         if (!any && req_valid[IDX_W'(idx)]) begin
            any = 1'b1;
            win = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/bla_arbiter.sv
// Round-robin arbiter sharing one bla_wrapper line-draw engine between NREQ requesters.
// Optional watchdog that aborts a stuck job: define BLA_ARB_TIMEOUT_EN.
module bla_arbiter
   import bla_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int COORD_W        = bla_pkg::COORD_W,
   parameter int TIMEOUT_CYCLES = 8192
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ-1:0]           req_vertice_num,
   input  logic [NREQ*COORD_W-1:0]   req_coordinates,
   output logic [NREQ-1:0]           req_ready,
   output logic [NREQ-1:0]           req_done,
   output logic [NREQ-1:0]           req_err,
   output logic                      bla_en,
   output logic                      vertice_num,
   output logic [COORD_W-1:0]        coordinates,
   input  logic                      bla_done,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   owner
);

   localparam int IDX_W = $clog2(NREQ);

   if (NREQ < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("bla_arbiter: NREQ and TIMEOUT_CYCLES must both be at least 2");
   end

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic               vnum_q, vnum_d;
   logic [COORD_W-1:0] coord_q, coord_d;

   logic               pick_any;
   logic [IDX_W-1:0]   pick_win;
   logic               timeout_hit;

   rr_picker #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .any       (pick_any),
      .win       (pick_win)
   );

`ifdef BLA_ARB_TIMEOUT_EN
   logic [31:0] wd_q, wd_d;
   logic        err_q, err_d;

   // Counter is zero on the first RUN cycle; the abort fires on the cycle it
   // would step to TIMEOUT_CYCLES-1, unless bla_done arrives in that cycle.
   assign timeout_hit = (state_q == RUN) && ((wd_q + 32'd1) == 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wd_d  = wd_q;
      err_d = err_q;
      if (state_q == IDLE) begin
         wd_d  = '0;
         err_d = 1'b0;
      end else if (state_q == RUN) begin
         wd_d  = wd_q + 32'd1;
         err_d = timeout_hit && !bla_done;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         vnum_q   <= 1'b0;
         coord_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         vnum_q   <= vnum_d;
         coord_q  <= coord_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_any) state_d = RUN;
         RUN:     if (bla_done || timeout_hit) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Job parameters are captured only on accept and held until the next accept.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      vnum_d   = vnum_q;
      coord_d  = coord_q;
      if (state_q == IDLE && pick_any) begin
         owner_d = pick_win;
         vnum_d  = req_vertice_num[pick_win];
         coord_d = req_coordinates[int'(pick_win)*COORD_W +: COORD_W];
      end
      if (state_q == RELEASE) begin
         rr_ptr_d = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);
      end
   end

   always_comb begin
      req_ready = '0;
      req_done  = '0;
      req_err   = '0;
      bla_en    = 1'b0;
      busy      = (state_q != IDLE);
      unique case (state_q)
         IDLE:    if (pick_any) req_ready[pick_win] = 1'b1;
         RUN:     bla_en = 1'b1;
         RELEASE: begin
            req_done[owner_q] = 1'b1;
`ifdef BLA_ARB_TIMEOUT_EN
            req_err[owner_q]  = err_q;
`endif
         end
         default: ;
      endcase
   end

   assign owner       = owner_q;
   assign vertice_num = vnum_q;
   assign coordinates = coord_q;

endmodule

// File: tb/tb_bla_arbiter.sv
// Randomized transaction-level bench for bla_arbiter with a round-robin reference model.
// Timeout scenario follows BLA_ARB_TIMEOUT_EN.
module tb_bla_arbiter;

   localparam int NREQ = 4;
   localparam int CW   = 48;
   localparam int TO   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_vertice_num;
   logic [NREQ*CW-1:0] req_coordinates;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   req_done;
   logic [NREQ-1:0]   req_err;
   logic              bla_en;
   logic              vertice_num;
   logic [CW-1:0]     coordinates;
   logic              bla_done;
   logic              busy;
   logic [1:0]        owner;

   int checks = 0;
   int errors = 0;
   int exp_ptr = 0;

   always #5 clk = ~clk;

   bla_arbiter #(
      .NREQ           (NREQ),
      .COORD_W        (CW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_vertice_num (req_vertice_num),
      .req_coordinates (req_coordinates),
      .req_ready       (req_ready),
      .req_done        (req_done),
      .req_err         (req_err),
      .bla_en          (bla_en),
      .vertice_num     (vertice_num),
      .coordinates     (coordinates),
      .bla_done        (bla_done),
      .busy            (busy),
      .owner           (owner)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NREQ-1:0] oh(input int i);
      return NREQ'(1) << i;
   endfunction

   // Reference rule: first pending requester scanning upward from the pointer, wrapping.
   function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
      for (int i = 0; i < NREQ; i++)
         if (m[(p + i) % NREQ]) return (p + i) % NREQ;
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; bla_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_ptr = 0;
   endtask

   task automatic present(input logic [NREQ-1:0] mask, input logic [CW-1:0] fixed,
                          output int win, output logic [CW-1:0] exp_c, output logic exp_v);
      logic [CW-1:0] c [NREQ];
      logic [NREQ-1:0] vn;
      for (int i = 0; i < NREQ; i++) begin
         c[i] = (fixed != '0) ? fixed : {16'($urandom), 32'($urandom)};
         req_coordinates[i*CW +: CW] = c[i];
      end
      vn = NREQ'($urandom);
      req_vertice_num = vn;
      req_valid = mask;
      #1;
      win = rr_pick(mask, exp_ptr);
      check("ready", req_ready, oh(win));
      check("busy_idle", busy, 0);
      exp_c = c[win];
      exp_v = vn[win];
   endtask

   // One job: accept, k RUN cycles (bla_done on the k-th), then RELEASE.
   // With give_done=0 the watchdog is expected to end RUN after TO-1 cycles.
   task automatic do_job(input logic [NREQ-1:0] mask, input int k, input bit perturb,
                         input bit give_done, input logic [CW-1:0] fixed);
      int win;
      logic [CW-1:0] exp_c;
      logic exp_v;
      int run_len;
      @(negedge clk);
      present(mask, fixed, win, exp_c, exp_v);
      run_len = give_done ? k : TO - 1;
      for (int j = 1; j <= run_len; j++) begin
         @(negedge clk);
         if (perturb && j == 2) begin
            for (int i = 0; i < NREQ; i++) req_coordinates[i*CW +: CW] = {16'($urandom), 32'($urandom)};
            req_vertice_num = ~req_vertice_num;
            req_valid = req_valid & ~oh(win);
         end
         bla_done = (give_done && j == k);
         #1;
         check("run_en", bla_en, 1);
         check("run_coord", coordinates, exp_c);
         check("run_vnum", vertice_num, exp_v);
         check("run_owner", owner, win);
         check("run_busy", busy, 1);
         check("run_done", req_done, 0);
         check("run_ready", req_ready, 0);
      end
      @(negedge clk);
      bla_done = 1'b0;
      #1;
      check("rel_done", req_done, oh(win));
      check("rel_err", req_err, give_done ? '0 : oh(win));
      check("rel_en", bla_en, 0);
      check("rel_owner", owner, win);
      check("rel_busy", busy, 1);
      check("rel_ready", req_ready, 0);
      req_valid = '0;
      exp_ptr = (win + 1) % NREQ;
   endtask

   initial begin
      int win;
      logic [CW-1:0] ec;
      logic ev;
      rst = 1'b1; req_valid = '0; req_vertice_num = '0; req_coordinates = '0; bla_done = 1'b0;

      // Reset state and ignored bla_done while idle
      do_reset();
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_done", req_done, 0);
      check("rst_err", req_err, 0);
      check("rst_en", bla_en, 0);
      check("rst_vnum", vertice_num, 0);
      check("rst_coord", coordinates, 0);
      check("rst_busy", busy, 0);
      check("rst_owner", owner, 0);
      @(negedge clk); bla_done = 1'b1;
      @(negedge clk); bla_done = 1'b0; #1;
      check("idle_done_ignored", req_done, 0);
      check("idle_busy", busy, 0);
      check("idle_en", bla_en, 0);

      // Single requester with fixed coordinates, done on the 5th RUN cycle
      do_job(4'b0100, 5, 1'b0, 1'b1, 48'h0A0B0C0D0E0F);

      // All requesters held: strict rotation from a fresh pointer
      do_reset();
      for (int n = 0; n < 5; n++) do_job(4'b1111, 3, 1'b0, 1'b1, '0);

      // Inputs disturbed mid-RUN
      do_job(4'b0110, 4, 1'b1, 1'b1, '0);

      // bla_done on the very cycle the watchdog would fire
      do_job(4'b1111, TO - 1, 1'b0, 1'b1, '0);

      // Randomized traffic
      for (int n = 0; n < 24; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_job(NREQ'($urandom_range(1, 15)), $urandom_range(1, 6), 1'($urandom), 1'b1, '0);
      end

      // Reset in the middle of a job
      do_reset();
      do_job(4'b0010, 2, 1'b0, 1'b1, '0);
      @(negedge clk);
      present(4'b0100, '0, win, ec, ev);
      repeat (2) @(negedge clk);
      rst = 1'b1; req_valid = '0;
      @(negedge clk);
      rst = 1'b0; #1;
      exp_ptr = 0;
      check("mid_rst_en", bla_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", req_done, 0);
      check("mid_rst_owner", owner, 0);
      @(negedge clk); #1;
      check("mid_rst_done2", req_done, 0);
      do_job(4'b1001, 2, 1'b0, 1'b1, '0);

      // Engine never completes
`ifdef BLA_ARB_TIMEOUT_EN
      do_job(4'b1000, 1, 1'b0, 1'b0, '0);
`else
      @(negedge clk);
      present(4'b1000, '0, win, ec, ev);
      for (int j = 0; j < 40; j++) begin
         @(negedge clk); #1;
         check("hang_busy", busy, 1);
         check("hang_en", bla_en, 1);
         check("hang_err", req_err, 0);
         check("hang_done", req_done, 0);
      end
      do_reset();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
